// File: rtl/axis_pkt_gearbox_if.sv
// axis_pkt_gearbox_if: beat-side and packet-side AXIS streams of the gearbox
interface axis_pkt_gearbox_if #(
  parameter int BEAT_W        = 64,
  parameter int BEATS_PER_PKT = 3
);
  localparam int PKT_W = BEAT_W * BEATS_PER_PKT;
  logic [BEAT_W-1:0] s_beat_tdata;
  logic              s_beat_tvalid;
  logic              s_beat_tlast;
  logic              s_beat_tready;
  logic [PKT_W-1:0]  m_pkt_tdata;
  logic              m_pkt_tvalid;
  logic              m_pkt_tready;
  logic [PKT_W-1:0]  s_pkt_tdata;
  logic              s_pkt_tvalid;
  logic              s_pkt_tready;
  logic [BEAT_W-1:0] m_beat_tdata;
  logic              m_beat_tvalid;
  logic              m_beat_tlast;
  logic              m_beat_tready;
  modport slave (
    input  s_beat_tdata, s_beat_tvalid, s_beat_tlast, m_pkt_tready,
    input  s_pkt_tdata, s_pkt_tvalid, m_beat_tready,
    output s_beat_tready, m_pkt_tdata, m_pkt_tvalid,
    output s_pkt_tready, m_beat_tdata, m_beat_tvalid, m_beat_tlast
  );
  modport master (
    output s_beat_tdata, s_beat_tvalid, s_beat_tlast, m_pkt_tready,
    output s_pkt_tdata, s_pkt_tvalid, m_beat_tready,
    input  s_beat_tready, m_pkt_tdata, m_pkt_tvalid,
    input  s_pkt_tready, m_beat_tdata, m_beat_tvalid, m_beat_tlast
  );
endinterface

// File: rtl/axis_pkt_gearbox.sv
// axis_pkt_gearbox: 64-bit beat <-> packet-word gearbox with framing check; GEARBOX_STATS_EN adds packet counters
module axis_pkt_gearbox #(
  parameter int BEAT_W        = 64,
  parameter int BEATS_PER_PKT = 3
) (
  input  logic                clk,
  input  logic                rstn,
  axis_pkt_gearbox_if.slave   bus,
  input  logic                flush,
  input  logic                clr_err,
  output logic                err_framing,
  output logic [31:0]         rx_pkt_cnt,
  output logic [31:0]         tx_pkt_cnt
);
  localparam int PKT_W = BEAT_W * BEATS_PER_PKT;
  localparam int IW = $clog2(BEATS_PER_PKT);
  localparam logic [IW-1:0] LAST = IW'(BEATS_PER_PKT - 1);
  typedef enum logic {IDLE, SEND} state_t;
  logic [IW-1:0]           ridx_q, tidx_q;
  logic [PKT_W-BEAT_W-1:0] asm_q;
  logic [PKT_W-1:0]        out_q, shift_q;
  logic                    out_vld_q, beat_vld_q, beat_last_q, err_q;
  state_t                  state_q;
  logic                    ridx_last, beat_in, pkt_out, pkt_in, beat_out, frame_evt;
  assign ridx_last          = ridx_q == LAST;
  assign bus.s_beat_tready  = !ridx_last || !out_vld_q || bus.m_pkt_tready;
  assign beat_in            = bus.s_beat_tvalid && bus.s_beat_tready;
  assign pkt_out            = out_vld_q && bus.m_pkt_tready;
  assign bus.s_pkt_tready   = state_q == IDLE || (beat_last_q && bus.m_beat_tready);
  assign pkt_in             = bus.s_pkt_tvalid && bus.s_pkt_tready;
  assign beat_out           = beat_vld_q && bus.m_beat_tready;
  assign frame_evt          = beat_in && !flush && (bus.s_beat_tlast != ridx_last);
  assign bus.m_pkt_tdata    = out_q;
  assign bus.m_pkt_tvalid   = out_vld_q;
  assign bus.m_beat_tdata   = shift_q[BEAT_W-1:0];
  assign bus.m_beat_tvalid  = beat_vld_q;
  assign bus.m_beat_tlast   = beat_last_q;
  assign err_framing        = err_q;
  // deserialiser: gather beats LSB-first, hand the full word to a separate output register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      ridx_q    <= '0;
      asm_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (flush) begin
      ridx_q    <= '0;
      asm_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (pkt_out) out_vld_q <= 1'b0;
      if (beat_in) begin
        if (ridx_last) begin
          out_q     <= {bus.s_beat_tdata, asm_q};
          out_vld_q <= 1'b1;
          ridx_q    <= '0;
        end else if (bus.s_beat_tlast) begin
          ridx_q <= '0;
        end else begin
          asm_q[ridx_q*BEAT_W +: BEAT_W] <= bus.s_beat_tdata;
          ridx_q <= ridx_q + 1'b1;
        end
      end
    end
  // serialiser FSM: IDLE takes a packet, SEND shifts it out; a new packet may load on the final beat
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      tidx_q      <= '0;
      beat_vld_q  <= 1'b0;
      beat_last_q <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      tidx_q      <= '0;
      beat_vld_q  <= 1'b0;
      beat_last_q <= 1'b0;
    end else if (pkt_in) begin
      state_q     <= SEND;
      shift_q     <= bus.s_pkt_tdata;
      tidx_q      <= '0;
      beat_vld_q  <= 1'b1;
      beat_last_q <= 1'b0;
    end else if (beat_out) begin
      shift_q     <= shift_q >> BEAT_W;
      tidx_q      <= beat_last_q ? '0 : tidx_q + 1'b1;
      beat_last_q <= !beat_last_q && (tidx_q + 1'b1 == LAST);
      beat_vld_q  <= !beat_last_q;
      state_q     <= beat_last_q ? IDLE : SEND;
    end
  // sticky framing flag; a fresh event beats a simultaneous clear
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) err_q <= 1'b0;
    else err_q <= frame_evt || (err_q && !clr_err);
`ifdef GEARBOX_STATS_EN
  logic [31:0] rx_cnt_q, tx_cnt_q;
  // packet counters survive flush; only reset clears them
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else if (!flush) begin
      rx_cnt_q <= rx_cnt_q + 32'(pkt_out);
      tx_cnt_q <= tx_cnt_q + 32'(pkt_in);
    end
  assign rx_pkt_cnt = rx_cnt_q;
  assign tx_pkt_cnt = tx_cnt_q;
`else
  assign rx_pkt_cnt = '0;
  assign tx_pkt_cnt = '0;
`endif
endmodule

// File: doc/axis_pkt_gearbox.md
Name: axis_pkt_gearbox

Overview:
- Beat/packet width converter between the duplex DMA's 64-bit memory-side beat streams and the 192-bit packet-side AXIS of the CGRA bridge.
- Downstream path (memory->CGRA): deserialises BEATS_PER_PKT beats into one packet word.
- Upstream path (CGRA->memory): serialises one packet word into BEATS_PER_PKT beats with tlast.
- Checks framing and keeps a sticky error flag that the SoC maps into the MMIO STATUS register.

Parameters:
BEAT_W, 64, beat width in bits (equals the AXI data width)
BEATS_PER_PKT, 3, beats per packet, legal range 2..8
PKT_W, BEAT_W*BEATS_PER_PKT (192), packet word width; derived, never overridden

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_beat_tdata  in  BEAT_W  downstream beat in
s_beat_tvalid  in  1  downstream beat valid
s_beat_tlast  in  1  marks final beat of a packet
s_beat_tready  out  1  downstream beat ready
m_pkt_tdata  out  PKT_W  assembled packet out
m_pkt_tvalid  out  1  packet valid
m_pkt_tready  in  1  packet ready
s_pkt_tdata  in  PKT_W  upstream packet in
s_pkt_tvalid  in  1  packet valid
s_pkt_tready  out  1  packet ready
m_beat_tdata  out  BEAT_W  upstream beat out
m_beat_tvalid  out  1  beat valid
m_beat_tlast  out  1  high on beat BEATS_PER_PKT-1
m_beat_tready  in  1  beat ready
flush  in  1  synchronous clear of both data paths
clr_err  in  1  clears err_framing
err_framing  out  1  sticky framing error
rx_pkt_cnt  out  32  packets emitted on m_pkt (feature-dependent)
tx_pkt_cnt  out  32  packets accepted on s_pkt (feature-dependent)

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rstn.
- Reset values: m_pkt_tvalid=0, m_beat_tvalid=0, m_beat_tlast=0, err_framing=0, both beat indices=0, counters=0, all data registers 0. s_beat_tready=1 and s_pkt_tready=1 once out of reset, because both paths are empty.
- Handshake rules: a transfer occurs when valid&&ready on the same edge. Valid, once asserted, holds with stable data until accepted. Ready never depends combinationally on the same interface's valid.

Deserialiser (downstream path):
- Beat k (index 0..BEATS_PER_PKT-1) is written to bits [k*BEAT_W +: BEAT_W]; beat 0 is the LSBs.
- The assembly register is separate from the output register.
- s_beat_tready = (idx != BEATS_PER_PKT-1) || !m_pkt_tvalid || m_pkt_tready.
- Throughput is 1 beat/cycle sustained.
- Accepting the final beat loads the output register. m_pkt_tvalid goes high the next cycle (1-cycle latency after the last beat), and idx wraps to 0.
- Early tlast (tlast on idx < BEATS_PER_PKT-1):
  - partial packet discarded, nothing emitted
  - idx returns to 0
  - err_framing set
- Missing tlast on the final beat: packet is emitted anyway (beat count is authoritative) and err_framing is set.

Serialiser (upstream path):
- States IDLE and SEND.
- IDLE: s_pkt_tready=1. A transfer loads the shift register, idx=0, and moves to SEND. The first beat is valid the next cycle.
- SEND: m_beat_tdata = shift[BEAT_W-1:0], m_beat_tlast = (idx==BEATS_PER_PKT-1).
- Each beat transfer shifts right by BEAT_W and increments idx.
- s_pkt_tready is also 1 in SEND while the final beat is being accepted, so a new packet loads in the same edge and no bubble is inserted.
- Without a new packet, the path returns to IDLE after the final beat.
- m_beat_tready low holds state indefinitely.

flush:
- Next edge: both paths return to empty/IDLE, both idx=0, all valids drop, held and partial data are dropped.
- Flush wins over any handshake on the same edge; data accepted on that edge is discarded.
- err_framing and the counters are unaffected.

Error flag:
- err_framing is set on any framing event and cleared by clr_err.
- A new framing event in the same cycle as clr_err leaves err_framing=1.

Optional Feature:
- Macro: GEARBOX_STATS_EN.
- Defined:
  - rx_pkt_cnt increments on each m_pkt transfer; tx_pkt_cnt increments on each s_pkt transfer.
  - 32-bit, wrap from 0xFFFF_FFFF to 0.
  - Cleared only by rstn, not by flush.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Beats 0x1111..., 0x2222..., 0x3333... with tlast on the third, m_pkt_tready=1 -> m_pkt_tdata = {0x3333..., 0x2222..., 0x1111...}, valid exactly 1 cycle after the third beat.
- 6 back-to-back beats with m_pkt_tready held low for 4 cycles after the first packet -> s_beat_tready drops only at idx=2, no beat is lost, both packets are correct, and rx_pkt_cnt=2 with the macro defined.
- Beat stream with tlast on beat 1 -> no packet emitted, err_framing=1; the next 3-beat packet assembles correctly; clr_err -> err_framing=0.
- Two packets on s_pkt, m_beat_tready=1 -> 6 consecutive beats with no bubble, beat 0 = bits[63:0], tlast on beats 2 and 5, s_pkt_tready high on the edge beat 2 is accepted.
- flush asserted mid-packet (deserialiser idx=1, serialiser mid-send) -> all valids 0 next cycle, the partial packet is never emitted, err_framing unchanged.
- rstn pulsed low asynchronously mid-transfer -> outputs immediately at reset values; normal operation after release.
